mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Schedules the single shared SRAM-like memory port between the IF stage (instruction fetch) and the MEM stage (load/store).
- Converts each requester's level-held request into one req/addr_ok/data_ok transaction.
- Returns read data with a one-cycle done pulse and raises stallreq to the pipeline control while any request is unserved.
- Sits between IF/MEM and the bus bridge, replacing direct inst_sram/data_sram wiring.

Parameters:
- DATA_PRIO, 1: 1 = data always wins a same-cycle conflict; 0 = round-robin, alternating on the last grant.
- TIMEOUT_CYC, 255: watchdog limit in cycles, used only with the optional feature.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- inst_req  in  1  IF fetch request, held until inst_done.
- inst_addr  in  32  fetch address, word aligned.
- inst_rdata  out  32  fetched instruction, valid with inst_done.
- inst_done  out  1  one-cycle completion pulse.
- data_req  in  1  MEM access request, held until data_done.
- data_wen  in  4  byte write strobes; 0 = read.
- data_addr  in  32  access address.
- data_wdata  in  32  store data.
- data_rdata  out  32  load data, valid with data_done.
- data_done  out  1  one-cycle completion pulse.
- flush  in  1  pipeline flush; cancels the instruction transaction only.
- stallreq  out  1  to pipeline control stall generation.
- mem_req  out  1  bus request.
- mem_wr  out  1  1 = write.
- mem_wstrb  out  4  byte strobes.
- mem_addr  out  32  bus address.
- mem_wdata  out  32  bus write data.
- mem_addr_ok  in  1  address accepted, same cycle as mem_req.
- mem_data_ok  in  1  data phase complete.
- mem_rdata  in  32  read data, valid with mem_data_ok.

Behaviour:
- Reset (rst=0, async):
  - FSM = IDLE; owner = INST; cancel = 0; last_grant = INST.
  - All mem_* outputs 0; all rdata outputs 0; both done outputs 0.
- FSM states: IDLE, ADDR, WAIT.
- IDLE:
  - Grant when any req is high and the requester did not get done in the previous cycle, so a held req is not re-served.
  - Capture owner, addr, wdata and wstrb into registers; go to ADDR next cycle.
- ADDR:
  - mem_req=1 and all mem_* driven from the captured registers.
  - mem_addr_ok=1 goes to WAIT.
- WAIT:
  - mem_req=0. mem_data_ok=1 latches mem_rdata into the owner's rdata register.
  - In the same edge, pulse the owner's done for one cycle and return to IDLE.
- Latency: minimum 3 cycles, from req seen in IDLE to the done pulse, with addr_ok and data_ok each arriving in the first cycle possible.
- Arbitration:
  - With DATA_PRIO=1, data wins a same-cycle conflict.
  - With DATA_PRIO=0, the requester not granted last wins; last_grant updates on each grant.
  - A losing request stays pending, with no drop.
- Flush with owner=INST:
  - In ADDR and addr_ok=0: withdraw mem_req and go to IDLE next cycle, with no done.
  - In ADDR and addr_ok=1, or in WAIT: set cancel. On data_ok, discard the data, suppress inst_done and clear cancel.
  - A flush while idle or while data owns the port has no effect.
- Data transactions are never cancelled.
- stallreq = (inst_req & ~inst_done & ~flush) | (data_req & ~data_done), combinational.
- mem_data_ok outside WAIT is ignored.
- rdata registers hold their value until the next completion for that owner.
- Reset asserted mid-transaction aborts it immediately. The bus side is responsible for discarding a late data_ok.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter clears on entry to ADDR and increments in ADDR and WAIT.
  - On reaching TIMEOUT_CYC, force a return to IDLE, pulse the owner's done with rdata=32'h0, and set the sticky output bus_err (extra port, 1 bit, cleared only by reset).
- Undefined: no counter and no bus_err port; the FSM may wait indefinitely.

Decomposition:
- Shared defines file:
  - FSM state encodings (ARB_IDLE, ARB_ADDR, ARB_WAIT) and owner codes (ARB_INST, ARB_DATA).
  - Widths of any request/response bus bundles, following the existing *_WD bus-width convention.
- One natural sub-module, arb_grant: combinational priority/round-robin pick plus the last_grant flop.
- The FSM and datapath registers stay in mem_arbiter.

Test Plan:
- Single fetch: inst_req=1, inst_addr=32'hbfc00000; addr_ok after 1 cycle, data_ok after 2 with rdata=32'h3c1d8000 -> one inst_done pulse, inst_rdata=32'h3c1d8000, stallreq low the cycle after.
- Conflict, DATA_PRIO=1: inst_req and data_req (data_wen=4'hf, addr 32'h80000010, wdata 32'hdeadbeef) rise together -> write issued first (mem_wr=1, mem_wstrb=4'hf), then the fetch; two separate done pulses; stallreq high throughout.
- Round-robin, DATA_PRIO=0: both requests held for 4 transactions -> grants alternate INST, DATA, INST, DATA.
- Flush in WAIT: fetch of 32'hbfc00004 accepted, flush=1 one cycle, data_ok 3 cycles later -> no inst_done, FSM IDLE, the next fetch of 32'hbfc00100 proceeds normally.
- Flush in ADDR with addr_ok held low -> mem_req drops next cycle, no transaction issued.
- Async reset: rst=0 mid-WAIT, between clock edges -> mem_req, both done outputs and the FSM clear immediately. With ARB_TIMEOUT_EN and TIMEOUT_CYC=8, no data_ok -> done after 8 cycles with rdata 0 and bus_err=1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM state and owner encodings plus bus-bundle widths shared by the memory arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_WAIT} arb_state_t;
  typedef enum logic {ARB_INST, ARB_DATA} arb_owner_t;
  localparam int ARB_REQ_WD = 69;
  localparam int ARB_RSP_WD = 33;
  localparam int ARB_CNT_WD = 16;
endpackage

// File: rtl/mem_arbiter_grant.sv
// arb_grant: picks the winner of the shared memory port; last_grant drives round-robin when DATA_PRIO=0.
module arb_grant
  import mem_arbiter_pkg::*;
#(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inst_req,
  input  logic       data_req,
  input  logic       take,
  output arb_owner_t grant
);
  arb_owner_t last_grant;
  always_comb
    grant = (inst_req && data_req)
          ? (DATA_PRIO ? ARB_DATA : (last_grant == ARB_INST ? ARB_DATA : ARB_INST))
          : (data_req ? ARB_DATA : ARB_INST);
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_grant <= ARB_INST;
    else if (take) last_grant <= grant;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM-like bus port between IF fetches and MEM loads/stores.
// Define ARB_TIMEOUT_EN to add a watchdog that aborts stuck transactions and raises bus_err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit DATA_PRIO   = 1'b1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_done,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  input  logic        flush,
  output logic        stallreq,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
`ifdef ARB_TIMEOUT_EN
  ,
  output logic        bus_err
`endif
);
  arb_state_t  state;
  arb_owner_t  owner, grant;
  logic        cancel, inst_ok, data_ok, take, withdraw, fin, expire, inst_cut;
  logic [31:0] rsp;
  // a requester whose done is pulsing this cycle is not re-served for the same held req
  assign inst_ok  = inst_req & ~inst_done;
  assign data_ok  = data_req & ~data_done;
  assign take     = state == ARB_IDLE && (inst_ok || data_ok);
  assign withdraw = state == ARB_ADDR && owner == ARB_INST && flush && !mem_addr_ok;
  assign fin      = (state == ARB_WAIT && mem_data_ok) || expire;
  assign inst_cut = cancel || flush;
  assign rsp      = expire ? '0 : mem_rdata;
  assign stallreq = (inst_req & ~inst_done & ~flush) | (data_req & ~data_done);
`ifdef ARB_TIMEOUT_EN
  logic [ARB_CNT_WD-1:0] cnt;
  assign expire = state != ARB_IDLE && cnt == ARB_CNT_WD'(TIMEOUT_CYC - 1) && !withdraw &&
                  !(state == ARB_WAIT && mem_data_ok);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      cnt     <= take ? '0 : (state != ARB_IDLE ? cnt + 1'b1 : cnt);
      bus_err <= bus_err | expire;
    end
`else
  assign expire = 1'b0;
`endif
  arb_grant #(.DATA_PRIO(DATA_PRIO)) u_grant (
    .clk      (clk),
    .rst      (rst),
    .inst_req (inst_ok),
    .data_req (data_ok),
    .take     (take),
    .grant    (grant)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= ARB_IDLE;
      owner      <= ARB_INST;
      cancel     <= 1'b0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wstrb  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_done  <= 1'b0;
      data_done  <= 1'b0;
    end else begin
      inst_done <= 1'b0;
      data_done <= 1'b0;
      case (state)
        ARB_IDLE: if (take) begin
          state     <= ARB_ADDR;
          owner     <= grant;
          mem_req   <= 1'b1;
          mem_wr    <= grant == ARB_DATA && |data_wen;
          mem_wstrb <= grant == ARB_DATA ? data_wen : '0;
          mem_addr  <= grant == ARB_DATA ? data_addr : inst_addr;
          mem_wdata <= grant == ARB_DATA ? data_wdata : '0;
        end
        ARB_ADDR: begin
          state   <= (fin || withdraw) ? ARB_IDLE : (mem_addr_ok ? ARB_WAIT : ARB_ADDR);
          mem_req <= !(fin || withdraw || mem_addr_ok);
          cancel  <= mem_addr_ok && !fin && owner == ARB_INST && flush;
        end
        ARB_WAIT: begin
          state  <= fin ? ARB_IDLE : ARB_WAIT;
          cancel <= !fin && (cancel || (owner == ARB_INST && flush));
        end
        default: state <= ARB_IDLE;
      endcase
      if (fin) begin
        if (owner == ARB_DATA) begin
          data_done  <= 1'b1;
          data_rdata <= rsp;
        end else if (!inst_cut) begin
          inst_done  <= 1'b1;
          inst_rdata <= rsp;
        end
      end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for flush, round-robin, reset and watchdog.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic inst_req = 1'b0, data_req = 1'b0, flush = 1'b0, mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0, mem_rdata = '0;
  logic [3:0] data_wen = '0;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic inst_done, data_done, stallreq, mem_req, mem_wr;
  logic [3:0] mem_wstrb;
  logic [31:0] r_inst_rdata, r_data_rdata, r_mem_addr, r_mem_wdata;
  logic r_inst_done, r_data_done, r_stallreq, r_mem_req, r_mem_wr;
  logic [3:0] r_mem_wstrb;
`ifdef ARB_TIMEOUT_EN
  logic bus_err, r_bus_err;
`endif
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_PRIO(1'b1), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_done(inst_done), .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done), .flush(flush),
    .stallreq(stallreq), .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
`ifdef ARB_TIMEOUT_EN
    , .bus_err(bus_err)
`endif
  );

  mem_arbiter #(.DATA_PRIO(1'b0)) rr (
    .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(r_inst_rdata),
    .inst_done(r_inst_done), .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(r_data_rdata), .data_done(r_data_done), .flush(flush),
    .stallreq(r_stallreq), .mem_req(r_mem_req), .mem_wr(r_mem_wr), .mem_wstrb(r_mem_wstrb),
    .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
`ifdef ARB_TIMEOUT_EN
    , .bus_err(r_bus_err)
`endif
  );

  typedef struct {
    logic ireq, dreq, aok, dok;
    logic [31:0] rd;
    logic mreq, mwr, idone, ddone, st;
    logic [31:0] addr, wdata;
    logic [3:0] wstrb;
    logic [31:0] irdata;
  } vec_t;
  vec_t v[13];

  function automatic vec_t mk(logic ireq, logic dreq, logic aok, logic dok, logic [31:0] rd,
                              logic mreq, logic mwr, logic idone, logic ddone, logic st,
                              logic [31:0] addr, logic [31:0] wdata, logic [3:0] wstrb,
                              logic [31:0] irdata);
    vec_t r;
    r.ireq = ireq; r.dreq = dreq; r.aok = aok; r.dok = dok; r.rd = rd;
    r.mreq = mreq; r.mwr = mwr; r.idone = idone; r.ddone = ddone; r.st = st;
    r.addr = addr; r.wdata = wdata; r.wstrb = wstrb; r.irdata = irdata;
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    inst_req = 0; data_req = 0; flush = 0; mem_addr_ok = 0; mem_data_ok = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // acts as the bus for one transaction of the selected instance; returns the issued address
  task automatic txn(input bit use_rr, input logic [31:0] rd, output logic [31:0] a);
    int n = 0;
    while (!(use_rr ? r_mem_req : mem_req) && n < 20) begin
      step();
      n++;
    end
    a = use_rr ? r_mem_addr : mem_addr;
    if (n >= 20) begin
      tests++;
      fails++;
      $display("FAIL txn wait: no mem_req within 20 cycles");
      a = 32'hffffffff;
    end
    mem_addr_ok = 1; step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = rd; step();
    mem_data_ok = 0;
  endtask

  initial begin
    logic [31:0] a;
    int k;
    v[0]  = mk(1,0,0,0,0,            0,0,0,0,1, 0,0,0, 0);
    v[1]  = mk(1,0,1,0,0,            1,0,0,0,1, 32'hbfc00000,0,0, 0);
    v[2]  = mk(1,0,0,1,32'h3c1d8000, 0,0,0,0,1, 0,0,0, 0);
    v[3]  = mk(1,0,0,0,0,            0,0,1,0,0, 0,0,0, 32'h3c1d8000);
    v[4]  = mk(0,0,0,0,0,            0,0,0,0,0, 0,0,0, 32'h3c1d8000);
    v[5]  = mk(1,1,0,0,0,            0,0,0,0,1, 0,0,0, 32'h3c1d8000);
    v[6]  = mk(1,1,1,0,0,            1,1,0,0,1, 32'h80000010,32'hdeadbeef,4'hf, 32'h3c1d8000);
    v[7]  = mk(1,1,0,1,0,            0,1,0,0,1, 0,0,0, 32'h3c1d8000);
    v[8]  = mk(1,1,0,0,0,            0,1,0,1,1, 0,0,0, 32'h3c1d8000);
    v[9]  = mk(1,0,1,0,0,            1,0,0,0,1, 32'hbfc00000,0,0, 32'h3c1d8000);
    v[10] = mk(1,0,0,1,32'h11223344, 0,0,0,0,1, 0,0,0, 32'h3c1d8000);
    v[11] = mk(1,0,0,0,0,            0,0,1,0,0, 0,0,0, 32'h11223344);
    v[12] = mk(0,0,0,0,0,            0,0,0,0,0, 0,0,0, 32'h11223344);

    do_reset();
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_wr", mem_wr, 0);
    chk("rst mem_wstrb", mem_wstrb, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst inst_rdata", inst_rdata, 0);
    chk("rst data_rdata", data_rdata, 0);
    chk("rst inst_done", inst_done, 0);
    chk("rst data_done", data_done, 0);
    chk("rst stallreq", stallreq, 0);

    inst_addr = 32'hbfc00000; data_addr = 32'h80000010; data_wdata = 32'hdeadbeef; data_wen = 4'hf;
    for (int i = 0; i < 13; i++) begin
      inst_req = v[i].ireq; data_req = v[i].dreq;
      mem_addr_ok = v[i].aok; mem_data_ok = v[i].dok; mem_rdata = v[i].rd;
      #1;
      chk($sformatf("row%0d mem_req", i), mem_req, v[i].mreq);
      chk($sformatf("row%0d mem_wr", i), mem_wr, v[i].mwr);
      chk($sformatf("row%0d inst_done", i), inst_done, v[i].idone);
      chk($sformatf("row%0d data_done", i), data_done, v[i].ddone);
      chk($sformatf("row%0d stallreq", i), stallreq, v[i].st);
      chk($sformatf("row%0d inst_rdata", i), inst_rdata, v[i].irdata);
      if (v[i].mreq) begin
        chk($sformatf("row%0d mem_addr", i), mem_addr, v[i].addr);
        chk($sformatf("row%0d mem_wdata", i), mem_wdata, v[i].wdata);
        chk($sformatf("row%0d mem_wstrb", i), mem_wstrb, v[i].wstrb);
      end
      step();
    end

    // round-robin: a lone data access leaves last_grant=DATA, so conflicts go INST, DATA, INST, DATA
    do_reset();
    data_wen = 0; data_addr = 32'h80000020; inst_addr = 32'hbfc00040;
    data_req = 1;
    txn(1, 32'h0, a);
    chk("rr lone data", a, 32'h80000020);
    data_req = 0; step(); step();
    for (int j = 0; j < 4; j++) begin
      inst_req = 1; data_req = 1;
      txn(1, 32'(j), a);
      chk($sformatf("rr grant%0d", j), a, (j % 2 == 0) ? 32'hbfc00040 : 32'h80000020);
      inst_req = 0; data_req = 0; step(); step();
    end

    // flush while the fetch waits for data
    do_reset();
    inst_addr = 32'hbfc00004; inst_req = 1; step();
    chk("fw mem_req", mem_req, 1);
    chk("fw mem_addr", mem_addr, 32'hbfc00004);
    mem_addr_ok = 1; step(); mem_addr_ok = 0;
    flush = 1; #1;
    chk("fw stall on flush", stallreq, 0);
    step(); flush = 0; inst_addr = 32'hbfc00100;
    step(); step();
    mem_data_ok = 1; mem_rdata = 32'haaaaaaaa; step(); mem_data_ok = 0;
    chk("fw no inst_done", inst_done, 0);
    chk("fw state idle", 32'(dut.state), 32'(ARB_IDLE));
    chk("fw rdata discarded", inst_rdata, 0);
    txn(0, 32'h12345678, a);
    chk("fw refetch addr", a, 32'hbfc00100);
    chk("fw refetch done", inst_done, 1);
    chk("fw refetch rdata", inst_rdata, 32'h12345678);
    inst_req = 0; step();

`ifdef ARB_TIMEOUT_EN
    inst_addr = 32'hbfc00300; inst_req = 1; step();
    k = 0; mem_addr_ok = 1;
    while (!inst_done && k < 20) begin
      step();
      mem_addr_ok = 0;
      k++;
    end
    chk("to cycles", k, 8);
    chk("to rdata zero", inst_rdata, 0);
    chk("to bus_err", bus_err, 1);
    inst_req = 0; step();
`endif

    // flush in ADDR with addr_ok low withdraws the request
    do_reset();
    inst_addr = 32'hbfc00200; inst_req = 1; step();
    chk("fa mem_req", mem_req, 1);
    flush = 1; step(); flush = 0; inst_req = 0; #1;
    chk("fa withdraw", mem_req, 0);
    chk("fa state idle", 32'(dut.state), 32'(ARB_IDLE));
    step();
    chk("fa still idle", mem_req, 0);
    chk("fa no done", inst_done, 0);

    // data_ok outside WAIT ignored; flush never cancels a data access
    data_wen = 0; data_addr = 32'h80000040;
    mem_data_ok = 1; mem_rdata = 32'hffffffff; step(); mem_data_ok = 0;
    chk("stray dok data_done", data_done, 0);
    chk("stray dok inst_done", inst_done, 0);
    chk("stray dok data_rdata", data_rdata, 0);
    data_req = 1; step();
    mem_addr_ok = 1; flush = 1; step(); mem_addr_ok = 0;
    step(); flush = 0;
    mem_data_ok = 1; mem_rdata = 32'hcafef00d; step(); mem_data_ok = 0; data_req = 0;
    chk("data flush done", data_done, 1);
    chk("data flush rdata", data_rdata, 32'hcafef00d);

    // asynchronous reset between edges
    inst_addr = 32'hbfc00400; inst_req = 1; step(); step();
    mem_addr_ok = 1; #1;
    chk("ar in ADDR", mem_req, 1);
    step(); mem_addr_ok = 0;
    chk("ar in WAIT", 32'(dut.state), 32'(ARB_WAIT));
    #2 rst = 0; #1;
    chk("ar state", 32'(dut.state), 32'(ARB_IDLE));
    chk("ar mem_req", mem_req, 0);
    chk("ar data_rdata", data_rdata, 0);
    #1 rst = 1;
    step();
    mem_addr_ok = 1; #1;
    chk("ar2 in ADDR", mem_req, 1);
    #2 rst = 0; #1;
    chk("ar2 mem_req", mem_req, 0);
    #1 rst = 1; mem_addr_ok = 0;
    txn(0, 32'h0badf00d, a);
    chk("ar3 done", inst_done, 1);
    #2 rst = 0; #1;
    chk("ar3 inst_done cleared", inst_done, 0);
    chk("ar3 inst_rdata cleared", inst_rdata, 0);
    inst_req = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
